data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the cpu memory port and the data memory.
//  - CPU side: 8-bit ADDRESS, READ/WRITE strobes, 8-bit data, BUSYWAIT.
//  - Memory side: 32-bit blocks addressed by 6-bit block number, with MEM_BUSYWAIT handshake.
//  - Hits complete with no stall. Misses stall the cpu via BUSYWAIT; the cpu freezes PC and register writes while it is high.
// PARAMETERS
//  NUM_BLOCKS   8   cache lines; index width = log2(NUM_BLOCKS) = 3
//  BLOCK_BYTES  4   bytes per line; offset width = 2; memory word = 32 bits
// PORTS
//  CLK            in   1   clock, all state updates on posedge
//  RESET          in   1   asynchronous, active-high reset
//  READ           in   1   cpu load request
//  WRITE          in   1   cpu store request
//  ADDRESS        in   8   cpu byte address: tag[7:5], index[4:2], offset[1:0]
//  WRITE_DATA     in   8   store data
//  READ_DATA      out  8   load data, valid while READ && !BUSYWAIT
//  BUSYWAIT       out  1   stall to cpu
//  MEM_READ       out  1   block fetch request
//  MEM_WRITE      out  1   block write-back request
//  MEM_ADDRESS    out  6   block address {tag,index}
//  MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
//  MEM_READDATA   in   32  fetched block, byte0 in [7:0]
//  MEM_BUSYWAIT   in   1   memory busy; raised in the same cycle as the request
// BEHAVIOUR
//  - Reset, asynchronous, overrides everything:
//    - state=IDLE; all valid and dirty bits = 0.
//    - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READ_DATA=0, BUSYWAIT=0.
//    - Data/tag arrays are not cleared.
//    - Reset mid-FETCH/WRITEBACK aborts the transfer; dirty data is lost.
//  - hit = valid[index] && tag[index]==ADDRESS[7:5], combinational.
//  - BUSYWAIT = (READ|WRITE) && !(state==IDLE && hit). Combinational; low with no request.
//  - READ and WRITE both high is illegal: treated as READ only; bench flags it.
//  - States:
//    - IDLE:
//      - Read hit: READ_DATA = byte[offset] combinationally, zero stall.
//      - Write hit: byte written on posedge, dirty=1, zero stall.
//      - Miss && !dirty -> FETCH. Miss && dirty -> WRITEBACK.
//    - WRITEBACK:
//      - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line.
//      - Completes on the first posedge after entry with MEM_BUSYWAIT=0 -> FETCH.
//    - FETCH:
//      - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
//      - On completion (same rule as WRITEBACK): line=MEM_READDATA, tag updated, valid=1, dirty=0 -> IDLE.
//      - Request then re-evaluates as a hit; a write lands on the next posedge.
//  - Completion edge: MEM_READ/MEM_WRITE are held until the completion edge and drop with the state change.
//  - Latency:
//    - Hit: 0 stall cycles.
//    - Clean miss: Tmem + 2 cycles.
//    - Dirty miss: 2*Tmem + 3 cycles.
//  - Request withdrawn (READ/WRITE low) during FETCH/WRITEBACK: the transfer still completes, then IDLE.
//  - Cpu holds ADDRESS, READ/WRITE and WRITE_DATA stable while BUSYWAIT=1.
// STRUCTURE
//  - Shared header dcache_defs.vh:
//    - field widths TAG_W=3, IDX_W=3, OFF_W=2;
//    - state encodings IDLE/WRITEBACK/FETCH.
//  - Sub-module dcache_array: valid/dirty/tag/data storage with async clear of valid/dirty.
//    - One line write port (fill) and one byte write port (store); combinational read.
//  - data_cache holds the FSM, hit logic and memory-port drivers.
// TESTING (memory model: MEM_BUSYWAIT high for 5 cycles per request)
//  1. Reset, READ 0x00; memory returns 32'hDDCCBBAA -> MEM_READ=1 with MEM_ADDRESS=6'h00, then READ_DATA=8'hAA, BUSYWAIT falls after 7 cycles.
//  2. READ 0x01 next -> READ_DATA=8'hBB same cycle, BUSYWAIT=0, MEM_READ stays 0.
//  3. WRITE 0x02 data 8'h55 -> no stall, no memory access; READ 0x02 returns 8'h55.
//  4. READ 0x22 (index 0, tag 1) -> MEM_WRITE=1 with MEM_ADDRESS=6'h00 and MEM_WRITEDATA=32'hDD55BBAA, then MEM_READ=1 with MEM_ADDRESS=6'h08.
//  5. READ 0x02 after step 4 (line clean) -> MEM_READ only, no MEM_WRITE; READ_DATA=8'h55 from memory.
//  6. RESET pulsed mid-FETCH -> MEM_READ and BUSYWAIT drop immediately, without a clock; the next READ 0x01 misses again.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: field widths,
// FSM state encoding, CPU address layout and a byte-select helper.
package data_cache_pkg;

  localparam int unsigned NUM_BLOCKS  = 8;
  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned TAG_W       = 3;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned OFF_W       = 2;
  localparam int unsigned ADDR_W      = TAG_W + IDX_W + OFF_W;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int unsigned MEM_ADDR_W  = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } state_t;

  // CPU byte address split into cache fields
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } cpu_addr_t;

  // Select byte 'off' of a line; byte0 lives in [7:0]
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] line,
                                                   input logic [OFF_W-1:0]   off);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (off == OFF_W'(i)) b = line[i*BYTE_W +: BYTE_W];
    end
    return b;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Storage for the data cache: valid/dirty bits (async cleared), tags and
// line data (never cleared). Combinational read of one line, one full-line
// fill port and one byte store port into the line currently being read.
// Ports:
//   CLK, RESET                       clock, async active-high reset
//   rd_index                         line selected for read and for stores
//   rd_valid/rd_dirty/rd_tag/rd_data contents of the selected line
//   fill_en/fill_index/fill_tag/fill_data   line refill from memory
//   store_en/store_offset/store_data        byte store into rd_index line
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               fill_en,
  input  logic [IDX_W-1:0]   fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               store_en,
  input  logic [OFF_W-1:0]   store_offset,
  input  logic [BYTE_W-1:0]  store_data
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  // Line status; fill and store are never active in the same cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
      dirty_q[fill_index] <= 1'b0;
    end else if (store_en) begin
      dirty_q[rd_index] <= 1'b1;
    end
  end

  // Tag and data payload, left untouched by reset
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end else if (store_en) begin
      for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
        if (store_offset == OFF_W'(b)) data_q[rd_index][b*BYTE_W +: BYTE_W] <= store_data;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// memory port and a 32-bit block memory. Hits complete with no stall;
// misses stall the CPU through BUSYWAIT while a dirty victim is written back
// and the missing block is fetched.
// Ports:
//   CLK, RESET              clock, async active-high reset
//   READ, WRITE             CPU load/store strobes (both high = load)
//   ADDRESS, WRITE_DATA     CPU byte address {tag,index,offset} and store data
//   READ_DATA, BUSYWAIT     load data (combinational on hit), CPU stall
//   MEM_READ, MEM_WRITE     registered block fetch / write-back requests
//   MEM_ADDRESS             registered block address {tag,index}
//   MEM_WRITEDATA           registered victim block, byte0 in [7:0]
//   MEM_READDATA            fetched block, byte0 in [7:0]
//   MEM_BUSYWAIT            memory busy, completion on first edge it is low
module data_cache
  import data_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [BYTE_W-1:0]     WRITE_DATA,
  output logic [BYTE_W-1:0]     READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_t             state;
  cpu_addr_t          addr_f;
  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic [TAG_W-1:0]   miss_tag;
  logic               hit;
  logic               req;
  logic               store_en;
  logic               fill_en;

  assign addr_f = cpu_addr_t'(ADDRESS);

  data_cache_array u_array (
    .CLK          (CLK),
    .RESET        (RESET),
    .rd_index     (addr_f.index),
    .rd_valid     (line_valid),
    .rd_dirty     (line_dirty),
    .rd_tag       (line_tag),
    .rd_data      (line_data),
    .fill_en      (fill_en),
    .fill_index   (MEM_ADDRESS[IDX_W-1:0]),
    .fill_tag     (miss_tag),
    .fill_data    (MEM_READDATA),
    .store_en     (store_en),
    .store_offset (addr_f.offset),
    .store_data   (WRITE_DATA)
  );

  // Hit detection, CPU stall and load data; READ has priority over WRITE
  always_comb begin
    hit       = line_valid && (line_tag == addr_f.tag);
    req       = READ || WRITE;
    BUSYWAIT  = req && !RESET && !((state == ST_IDLE) && hit);
    store_en  = (state == ST_IDLE) && hit && WRITE && !READ;
    fill_en   = (state == ST_FETCH) && !MEM_BUSYWAIT;
    READ_DATA = '0;
    if (READ && !RESET && (state == ST_IDLE) && hit) READ_DATA = block_byte(line_data, addr_f.offset);
  end

  // Miss handling FSM with registered memory-port outputs. The miss tag is
  // captured at miss time so a withdrawn request still fills the right line.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      miss_tag      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !hit) begin
            miss_tag <= addr_f.tag;
            if (line_valid && line_dirty) begin
              state         <= ST_WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {line_tag, addr_f.index};
              MEM_WRITEDATA <= line_data;
            end else begin
              state       <= ST_FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {addr_f.tag, addr_f.index};
            end
          end
        end
        ST_WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= ST_FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {miss_tag, MEM_ADDRESS[IDX_W-1:0]};
          end
        end
        ST_FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state    <= ST_IDLE;
            MEM_READ <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table of CPU accesses, a few
// hand-written multi-cycle sequences (illegal READ+WRITE, withdrawn request,
// reset mid-fetch) and a randomized phase against a cache/memory model.
module tb_data_cache;

  localparam int MEM_LAT     = 5;
  localparam int STALL_LIMIT = 40;
  localparam int NUM_VECS    = 9;
  localparam int NUM_RAND    = 120;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [7:0]  WRITE_DATA = '0;
  logic [7:0]  READ_DATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int checks = 0;
  int failures = 0;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITE_DATA    (WRITE_DATA),
    .READ_DATA     (READ_DATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Block memory: busy for MEM_LAT cycles per request, completes on the
  // first edge it is not busy. Preloaded from load_img on load_req.
  logic [31:0] mem      [64];
  logic [31:0] load_img [64];
  logic        load_req = 1'b0;
  int          mem_cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < MEM_LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= load_img[i];
    end
    if (RESET) begin
      mem_cnt <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt < MEM_LAT) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One CPU access, started #1 after a posedge; returns observed stall
  // cycles, load data and the first memory requests seen during the stall.
  task automatic do_access(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                           output int stall, output logic [7:0] rdata,
                           output bit saw_mr, output logic [5:0] mr_addr,
                           output bit saw_mw, output logic [5:0] mw_addr, output logic [31:0] mw_data);
    bit done;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
    stall = 0; done = 0; saw_mr = 0; saw_mw = 0;
    mr_addr = '0; mw_addr = '0; mw_data = '0; rdata = '0;
    for (int c = 0; c < STALL_LIMIT; c++) begin
      @(negedge CLK);
      if (MEM_READ && !saw_mr) begin saw_mr = 1; mr_addr = MEM_ADDRESS; end
      if (MEM_WRITE && !saw_mw) begin saw_mw = 1; mw_addr = MEM_ADDRESS; mw_data = MEM_WRITEDATA; end
      if (!BUSYWAIT) begin done = 1; break; end
      stall++;
    end
    if (!done) check("busywait_timeout", 32'(BUSYWAIT), 32'd0);
    rdata = READ_DATA;
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  stall;
    logic [7:0]  rdata;
    logic        mr;
    logic [5:0]  mr_addr;
    logic        mw;
    logic [5:0]  mw_addr;
    logic [31:0] mw_data;
  } vec_t;

  vec_t        vecs [NUM_VECS];
  int          st;
  logic [7:0]  rdv;
  bit          smr, smw;
  logic [5:0]  mra, mwa;
  logic [31:0] mwd;

  // Reference state for the random phase
  logic [7:0]  ref_bytes [256];
  bit          ref_valid [8];
  bit          ref_dirty [8];
  logic [2:0]  ref_tag   [8];

  task automatic pulse_reset();
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); #1;
  endtask

  task automatic load_memory();
    load_req = 1;
    @(posedge CLK); #1;
    load_req = 0;
  endtask

  initial begin
    // Directed image: block 0, block 8 and block 0x20 preloaded
    for (int i = 0; i < 64; i++) load_img[i] = '0;
    load_img[0]    = 32'hDDCCBBAA;
    load_img[8]    = 32'h44332211;
    load_img[6'h20] = 32'hA1B2C3D4;

    #1 RESET = 1;
    #2;
    check("rst_read_data", 32'(READ_DATA), 32'h0);
    check("rst_busywait", 32'(BUSYWAIT), 32'h0);
    check("rst_mem_read", 32'(MEM_READ), 32'h0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    check("rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    load_memory();
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); #1;

    // rd wr addr wdata stall rdata mr mr_addr mw mw_addr mw_data
    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'd7,  8'hAA, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'd0,  8'hBB, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 8'h02, 8'h55, 8'd0,  8'h00, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'd0,  8'h55, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 8'h22, 8'h00, 8'd13, 8'h33, 1'b1, 6'h08, 1'b1, 6'h00, 32'hDD55BBAA};
    vecs[5] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'd7,  8'h55, 1'b1, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 8'h23, 8'h99, 8'd7,  8'h00, 1'b1, 6'h08, 1'b0, 6'h00, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 8'h23, 8'h00, 8'd0,  8'h99, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'd13, 8'hDD, 1'b1, 6'h00, 1'b1, 6'h08, 32'h99332211};

    for (int v = 0; v < NUM_VECS; v++) begin
      do_access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, st, rdv, smr, mra, smw, mwa, mwd);
      check($sformatf("vec%0d_stall", v), 32'(st), 32'(vecs[v].stall));
      if (vecs[v].rd) check($sformatf("vec%0d_rdata", v), 32'(rdv), 32'(vecs[v].rdata));
      check($sformatf("vec%0d_mem_read", v), 32'(smr), 32'(vecs[v].mr));
      if (vecs[v].mr) check($sformatf("vec%0d_mr_addr", v), 32'(mra), 32'(vecs[v].mr_addr));
      check($sformatf("vec%0d_mem_write", v), 32'(smw), 32'(vecs[v].mw));
      if (vecs[v].mw) begin
        check($sformatf("vec%0d_mw_addr", v), 32'(mwa), 32'(vecs[v].mw_addr));
        check($sformatf("vec%0d_mw_data", v), mwd, vecs[v].mw_data);
      end
    end

    // READ and WRITE together: handled as a load, store discarded
    $display("note: driving READ and WRITE together (illegal), expecting load behaviour");
    do_access(1'b1, 1'b1, 8'h03, 8'h77, st, rdv, smr, mra, smw, mwa, mwd);
    check("rw_stall", 32'(st), 32'd0);
    check("rw_rdata", 32'(rdv), 32'hDD);
    do_access(1'b1, 1'b0, 8'h03, 8'h00, st, rdv, smr, mra, smw, mwa, mwd);
    check("rw_no_store", 32'(rdv), 32'hDD);

    // Request withdrawn mid-fetch: transfer still completes and fills
    READ = 1; ADDRESS = 8'h81;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("wd_mem_read", 32'(MEM_READ), 32'h1);
    check("wd_mem_addr", 32'(MEM_ADDRESS), 32'h20);
    READ = 0;
    #1;
    check("wd_busywait_idle", 32'(BUSYWAIT), 32'h0);
    begin
      bit dropped;
      dropped = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge CLK);
        if (!MEM_READ) begin dropped = 1; break; end
      end
      check("wd_fetch_done", 32'(dropped), 32'h1);
    end
    @(posedge CLK); #1;
    do_access(1'b1, 1'b0, 8'h81, 8'h00, st, rdv, smr, mra, smw, mwa, mwd);
    check("wd_hit_stall", 32'(st), 32'd0);
    check("wd_hit_rdata", 32'(rdv), 32'hC3);

    // Reset in the middle of a fetch drops everything without a clock
    READ = 1; ADDRESS = 8'h41;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rf_mem_read_pre", 32'(MEM_READ), 32'h1);
    check("rf_busywait_pre", 32'(BUSYWAIT), 32'h1);
    #2 RESET = 1;
    #1;
    check("rf_mem_read_async", 32'(MEM_READ), 32'h0);
    check("rf_busywait_async", 32'(BUSYWAIT), 32'h0);
    check("rf_mem_addr_async", 32'(MEM_ADDRESS), 32'h0);
    READ = 0;
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); #1;
    do_access(1'b1, 1'b0, 8'h01, 8'h00, st, rdv, smr, mra, smw, mwa, mwd);
    check("rf_remiss_stall", 32'(st), 32'd7);
    check("rf_remiss_mr", 32'(smr), 32'h1);
    check("rf_remiss_mr_addr", 32'(mra), 32'h00);
    check("rf_remiss_rdata", 32'(rdv), 32'hBB);

    // Random phase against a cache-state plus byte-memory model
    for (int i = 0; i < 64; i++) load_img[i] = $urandom;
    load_memory();
    pulse_reset();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] a8;
      a8 = 8'(a);
      ref_bytes[a] = load_img[a8[7:2]][8*a8[1:0] +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = '0;
    end

    for (int n = 0; n < NUM_RAND; n++) begin
      logic [7:0]  a;
      logic [7:0]  wd;
      logic [2:0]  idx, tg;
      bit          rd, e_hit, e_wb;
      int          e_stall;
      logic [31:0] e_wb_data;
      tg = 3'($urandom_range(0, 3));
      idx = 3'($urandom_range(0, 7));
      a = {tg, idx, 2'($urandom_range(0, 3))};
      wd = 8'($urandom);
      rd = $urandom_range(0, 1) == 1;
      e_hit = ref_valid[idx] && (ref_tag[idx] == tg);
      e_wb = !e_hit && ref_valid[idx] && ref_dirty[idx];
      e_stall = e_hit ? 0 : (e_wb ? 2 * MEM_LAT + 3 : MEM_LAT + 2);
      e_wb_data = {ref_bytes[{ref_tag[idx], idx, 2'd3}], ref_bytes[{ref_tag[idx], idx, 2'd2}],
                   ref_bytes[{ref_tag[idx], idx, 2'd1}], ref_bytes[{ref_tag[idx], idx, 2'd0}]};

      do_access(rd, !rd, a, wd, st, rdv, smr, mra, smw, mwa, mwd);
      check($sformatf("rnd%0d_stall", n), 32'(st), 32'(e_stall));
      check($sformatf("rnd%0d_mem_read", n), 32'(smr), 32'(!e_hit));
      if (!e_hit) check($sformatf("rnd%0d_mr_addr", n), 32'(mra), 32'({tg, idx}));
      check($sformatf("rnd%0d_mem_write", n), 32'(smw), 32'(e_wb));
      if (e_wb) begin
        check($sformatf("rnd%0d_mw_addr", n), 32'(mwa), 32'({ref_tag[idx], idx}));
        check($sformatf("rnd%0d_mw_data", n), mwd, e_wb_data);
      end
      if (rd) check($sformatf("rnd%0d_rdata", n), 32'(rdv), 32'(ref_bytes[a]));

      if (!e_hit) begin
        ref_valid[idx] = 1; ref_tag[idx] = tg; ref_dirty[idx] = 0;
      end
      if (!rd) begin
        ref_bytes[a] = wd;
        ref_dirty[idx] = 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
